// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with in-order dispatch/commit, NUM_CDB out-of-order completion ports and mispredict squash
module rob_multiport #(
  parameter int DEPTH = 32,
  parameter int NUM_CDB = 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic [4:0]               disp_rd_addr_i,
  input  logic                     disp_is_branch_i,
  output logic [IDX_W-1:0]         disp_rob_idx_o,
  input  logic [NUM_CDB-1:0]       cdb_valid_i,
  input  logic [NUM_CDB*IDX_W-1:0] cdb_rob_idx_i,
  input  logic [NUM_CDB*32-1:0]    cdb_data_i,
  input  logic [NUM_CDB-1:0]       cdb_mispredict_i,
  input  logic [NUM_CDB*32-1:0]    cdb_target_i,
  output logic                     commit_valid_o,
  input  logic                     commit_ready_i,
  output logic [4:0]               commit_rd_addr_o,
  output logic [31:0]              commit_rd_data_o,
  output logic [IDX_W-1:0]         commit_rob_idx_o,
  output logic                     flush_o,
  output logic [31:0]              flush_target_o,
  output logic [IDX_W-1:0]         head_idx_o,
  output logic [IDX_W-1:0]         tail_idx_o,
  output logic [IDX_W:0]           count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  logic [DEPTH-1:0] valid, done, is_br, mis;
  logic [4:0]       rd_addr [DEPTH];
  logic [31:0]      rd_data [DEPTH];
  logic [31:0]      target  [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] cidx [NUM_CDB];
  logic             disp_fire, commit_fire, squash;

  always_comb
    for (int p = 0; p < NUM_CDB; p++) cidx[p] = cdb_rob_idx_i[p*IDX_W +: IDX_W];

  assign full_o           = count == (IDX_W+1)'(DEPTH);
  assign empty_o          = count == '0;
  assign commit_valid_o   = valid[head] & done[head];
  assign disp_ready_o     = !full_o & !(commit_valid_o & mis[head]);
  assign disp_fire        = disp_valid_i & disp_ready_o;
  assign commit_fire      = commit_valid_o & commit_ready_i;
  assign squash           = commit_fire & mis[head];
  assign disp_rob_idx_o   = tail;
  assign commit_rd_addr_o = rd_addr[head];
  assign commit_rd_data_o = rd_data[head];
  assign commit_rob_idx_o = head;
  assign head_idx_o       = head;
  assign tail_idx_o       = tail;
  assign count_o          = count;

  // later ports overwrite earlier ones, so the highest-numbered port wins a collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid          <= '0;
      done           <= '0;
      is_br          <= '0;
      mis            <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      flush_o        <= 1'b0;
      flush_target_o <= '0;
    end else begin
      flush_o <= squash;
      if (squash) flush_target_o <= target[head];
      for (int p = 0; p < NUM_CDB; p++)
        if (cdb_valid_i[p] && valid[cidx[p]]) begin
          done[cidx[p]] <= 1'b1;
          if (is_br[cidx[p]]) mis[cidx[p]] <= cdb_mispredict_i[p];
        end
      if (disp_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        is_br[tail] <= disp_is_branch_i;
        mis[tail]   <= 1'b0;
        tail        <= tail + 1'b1;
      end
      if (commit_fire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (squash) begin
        valid <= '0;
        tail  <= head + 1'b1;
        count <= '0;
      end else
        count <= count + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(commit_fire);
    end

  // payload needs no reset: it is only observed behind valid/done
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid_i[p] && valid[cidx[p]]) begin
        rd_data[cidx[p]] <= cdb_data_i[p*32 +: 32];
        if (is_br[cidx[p]]) target[cidx[p]] <= cdb_target_i[p*32 +: 32];
      end
    if (disp_fire) rd_addr[tail] <= disp_rd_addr_i;
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed scenarios plus random traffic checked against a queue-style ROB model
module tb_rob_multiport;
  localparam int D = 32, N = 2, W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           disp_valid, disp_ready, disp_br, commit_valid, commit_ready, flush, full, empty;
  logic [4:0]     disp_rd, commit_rd;
  logic [W-1:0]   disp_idx, commit_idx, head_idx, tail_idx;
  logic [N-1:0]   cdb_valid, cdb_mis;
  logic [N*W-1:0] cdb_idx;
  logic [N*32-1:0] cdb_data, cdb_tgt;
  logic [31:0]    commit_data, flush_tgt;
  logic [W:0]     count;

  rob_multiport #(.DEPTH(D), .NUM_CDB(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_rd_addr_i(disp_rd),
    .disp_is_branch_i(disp_br), .disp_rob_idx_o(disp_idx),
    .cdb_valid_i(cdb_valid), .cdb_rob_idx_i(cdb_idx), .cdb_data_i(cdb_data),
    .cdb_mispredict_i(cdb_mis), .cdb_target_i(cdb_tgt),
    .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_rd_addr_o(commit_rd),
    .commit_rd_data_o(commit_data), .commit_rob_idx_o(commit_idx),
    .flush_o(flush), .flush_target_o(flush_tgt),
    .head_idx_o(head_idx), .tail_idx_o(tail_idx), .count_o(count),
    .full_o(full), .empty_o(empty)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: occupied entries are the window [m_head, m_head+m_cnt) modulo D
  int          m_head, m_cnt;
  bit          m_done [D];
  bit          m_br   [D];
  bit          m_mis  [D];
  logic [4:0]  m_rd   [D];
  logic [31:0] m_data [D];
  logic [31:0] m_tgt  [D];
  bit          m_flush;
  logic [31:0] m_ftgt;

  function automatic bit live(input int i);
    return ((i - m_head + D) % D) < m_cnt;
  endfunction
  function automatic int m_tail();
    return (m_head + m_cnt) % D;
  endfunction
  function automatic bit m_cv();
    return m_cnt > 0 && m_done[m_head];
  endfunction
  function automatic bit m_dr();
    return m_cnt < D && !(m_cv() && m_mis[m_head]);
  endfunction

  task automatic m_reset();
    m_head = 0; m_cnt = 0; m_flush = 0; m_ftgt = '0;
    for (int i = 0; i < D; i++) begin m_done[i] = 0; m_br[i] = 0; m_mis[i] = 0; end
  endtask

  task automatic m_update();
    bit cv, df, cf, sq;
    logic [31:0] t;
    int tl;
    cv = m_cv(); df = disp_valid && m_dr(); cf = cv && commit_ready;
    sq = cf && m_mis[m_head]; t = m_tgt[m_head]; tl = m_tail();
    for (int p = 0; p < N; p++) begin
      int ix;
      ix = int'(cdb_idx[p*W +: W]);
      if (cdb_valid[p] && live(ix)) begin
        m_done[ix] = 1;
        m_data[ix] = cdb_data[p*32 +: 32];
        if (m_br[ix]) begin m_mis[ix] = cdb_mis[p]; m_tgt[ix] = cdb_tgt[p*32 +: 32]; end
      end
    end
    m_flush = sq;
    if (sq) begin
      m_ftgt = t; m_head = (m_head + 1) % D; m_cnt = 0;
    end else begin
      if (df) begin m_done[tl] = 0; m_br[tl] = disp_br; m_mis[tl] = 0; m_rd[tl] = disp_rd; end
      if (cf) m_head = (m_head + 1) % D;
      m_cnt += int'(df) - int'(cf);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), m_cnt);
    chk("head", 32'(head_idx), m_head);
    chk("tail", 32'(tail_idx), m_tail());
    chk("disp_idx", 32'(disp_idx), m_tail());
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("full", 32'(full), 32'(m_cnt == D));
    chk("disp_ready", 32'(disp_ready), 32'(m_dr()));
    chk("commit_valid", 32'(commit_valid), 32'(m_cv()));
    chk("commit_idx", 32'(commit_idx), m_head);
    if (m_cv()) begin
      chk("commit_rd", 32'(commit_rd), 32'(m_rd[m_head]));
      chk("commit_data", commit_data, m_data[m_head]);
    end
    chk("flush", 32'(flush), 32'(m_flush));
    if (m_flush) chk("flush_target", flush_tgt, m_ftgt);
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 0; disp_rd = '0; disp_br = 0; commit_ready = 0;
    cdb_valid = '0; cdb_idx = '0; cdb_data = '0; cdb_mis = '0; cdb_tgt = '0;
  endtask

  task automatic set_cdb(input int p, input int idx, input logic [31:0] d, input bit m, input logic [31:0] t);
    cdb_valid[p] = 1'b1;
    cdb_idx[p*W +: W] = W'(idx);
    cdb_data[p*32 +: 32] = d;
    cdb_mis[p] = m;
    cdb_tgt[p*32 +: 32] = t;
  endtask

  initial begin
    idle(); m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    // three dispatches, then out-of-order completion with in-order retirement
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1; disp_rd = 5'(i + 1);
      chk("seq_disp_idx", 32'(disp_idx), i);
      tick();
    end
    idle();
    chk("seq_count3", 32'(count), 3);
    chk("seq_cv0", 32'(commit_valid), 0);
    set_cdb(1, 2, 32'hC, 0, 0); tick(); idle();
    set_cdb(0, 0, 32'hA, 0, 0); commit_ready = 1; tick(); idle(); commit_ready = 1;
    chk("c0_valid", 32'(commit_valid), 1);
    chk("c0_rd", 32'(commit_rd), 1);
    chk("c0_data", commit_data, 32'hA);
    tick();
    chk("stall_cv", 32'(commit_valid), 0);
    tick(); tick();
    chk("stall_head", 32'(head_idx), 1);
    set_cdb(0, 1, 32'hB, 0, 0); tick(); idle(); commit_ready = 1;
    chk("c1_idx", 32'(commit_idx), 1);
    tick();
    chk("c2_rd", 32'(commit_rd), 3);
    chk("c2_data", commit_data, 32'hC);
    tick();
    chk("drain_empty", 32'(empty), 1);
    // mispredicted branch at idx4 with three younger entries
    idle();
    for (int i = 0; i < 5; i++) begin
      disp_valid = 1; disp_rd = 5'(9 + i); disp_br = (i == 1);
      tick();
    end
    idle();
    set_cdb(0, 3, 32'h33, 0, 0); set_cdb(1, 4, 32'h44, 1, 32'h400); tick(); idle();
    commit_ready = 1; tick();
    chk("sq_ready", 32'(disp_ready), 0);
    disp_valid = 1; set_cdb(0, 5, 32'h55, 0, 0);
    tick(); idle();
    chk("sq_flush", 32'(flush), 1);
    chk("sq_target", flush_tgt, 32'h400);
    chk("sq_count", 32'(count), 0);
    chk("sq_head", 32'(head_idx), 5);
    chk("sq_tail", 32'(tail_idx), 5);
    tick();
    chk("sq_flush_low", 32'(flush), 0);
    // colliding CDB writes and a write to an unallocated entry
    for (int i = 0; i < 3; i++) begin disp_valid = 1; disp_rd = 5'(20 + i); tick(); end
    idle();
    set_cdb(0, 7, 32'h11, 0, 0); set_cdb(1, 7, 32'h22, 0, 0); tick(); idle();
    set_cdb(0, 20, 32'hDEAD, 1, 32'h1234); tick(); idle();
    chk("unalloc_count", 32'(count), 3);
    chk("unalloc_cv", 32'(commit_valid), 0);
    set_cdb(0, 5, 32'h5, 0, 0); set_cdb(1, 6, 32'h6, 0, 0); tick(); idle();
    commit_ready = 1; tick(); tick();
    chk("dup_idx", 32'(commit_idx), 7);
    chk("dup_data", commit_data, 32'h22);
    tick();
    // fill, commit while full, then stream across the wrap
    idle(); disp_valid = 1;
    for (int i = 0; i < D; i++) begin disp_rd = 5'(i); tick(); end
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(disp_ready), 0);
    idle(); set_cdb(0, m_head, 32'h88, 0, 0); tick(); idle();
    disp_valid = 1; commit_ready = 1; tick();
    chk("full_commit_count", 32'(count), D - 1);
    for (int i = 0; i < 40; i++) begin
      idle(); disp_valid = 1; commit_ready = 1; disp_rd = 5'(i);
      set_cdb(0, m_head, $urandom, 0, 0); set_cdb(1, (m_head + 1) % D, $urandom, 0, 0);
      tick();
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      disp_valid = ($urandom % 4) != 0; disp_rd = 5'($urandom); disp_br = ($urandom % 3) == 0;
      commit_ready = ($urandom % 4) != 0;
      for (int p = 0; p < N; p++)
        if ($urandom % 2)
          set_cdb(p, ($urandom % 8 == 0) ? int'($urandom % D) : (m_head + int'($urandom % (m_cnt > 0 ? m_cnt : 1))) % D,
                  $urandom, ($urandom % 6) == 0, $urandom);
      tick();
    end
    // asynchronous reset with a squash pending at the next edge
    idle(); rst_n = 1'b0; m_reset(); #1; @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin disp_valid = 1; disp_br = (i == 0); disp_rd = 5'(i + 1); tick(); end
    idle(); set_cdb(0, 0, 32'h1, 1, 32'h900); tick(); idle();
    commit_ready = 1;
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_outputs();
    @(posedge clk); #1;
    chk("arst_flush", 32'(flush), 0);
    chk("arst_count", 32'(count), 0);
    @(negedge clk); rst_n = 1'b1; idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer that replaces the single-CDB ROB in the out-of-order core. It sits between dispatch and the regfile commit stage. Entries are allocated in order and completed out of order from NUM_CDB result buses. They retire in order through a ready/valid commit handshake. A retiring mispredicted branch squashes every younger entry and raises a one-cycle flush with a redirect target.

## Interface
Parameters:
- DEPTH, 32, entry count; power of two, ≥2
- NUM_CDB, 2, number of result-bus write ports, ≥1
- IDX_W, $clog2(DEPTH), derived; entry index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  ROB can accept a dispatch this cycle
- disp_rd_addr_i  in  5  destination arch register
- disp_is_branch_i  in  1  instruction is a branch/jump
- disp_rob_idx_o  out  IDX_W  index that the dispatch will receive; equals tail
- cdb_valid_i  in  NUM_CDB  per-port result valid
- cdb_rob_idx_i  in  NUM_CDB×IDX_W  per-port target entry
- cdb_data_i  in  NUM_CDB×32  per-port result data
- cdb_mispredict_i  in  NUM_CDB  per-port branch mispredict flag
- cdb_target_i  in  NUM_CDB×32  per-port correct redirect PC
- commit_valid_o  out  1  head entry is done and may retire
- commit_ready_i  in  1  commit stage accepts head
- commit_rd_addr_o  out  5  head rd
- commit_rd_data_o  out  32  head result
- commit_rob_idx_o  out  IDX_W  head index
- flush_o  out  1  one-cycle squash pulse
- flush_target_o  out  32  redirect PC; valid while flush_o=1
- head_idx_o, tail_idx_o  out  IDX_W  pointers
- count_o  out  IDX_W+1  occupied entries, 0..DEPTH
- full_o, empty_o  out  1  count_o==DEPTH / count_o==0

## Operation
- Entry fields: valid, done, is_branch, mispredict, rd_addr[4:0], rd_data[31:0], target[31:0].
- Dispatch fire = disp_valid_i & disp_ready_o.
  - On fire, the entry at tail is written with valid=1, done=0, mispredict=0, and the dispatched rd and is_branch.
  - tail advances by 1 and wraps from DEPTH-1 to 0.
- disp_ready_o = !full_o & !(commit_valid_o & head.mispredict).
  - Dispatch is not accepted in the cycle a squash may fire.
  - A full ROB does not take dispatch credit from a same-cycle commit.
- CDB write, per port p with cdb_valid_i[p]:
  - If entry cdb_rob_idx_i[p] is valid, set done=1 and write rd_data.
  - If the entry's is_branch=1, also capture mispredict and target.
  - A write to an invalid entry is ignored.
  - If two ports target the same index in one cycle, the higher port number wins.
- Commit:
  - commit_valid_o = head.valid & head.done, combinational from state.
  - commit_* outputs reflect the head entry at all times.
  - Commit fire = commit_valid_o & commit_ready_i. On fire, head.valid←0 and head advances with wrap.
- Squash: a commit fire whose head has mispredict=1.
  - All entries are set valid=0.
  - tail←head+1 (wrapped), head←head+1, count←0.
  - Next cycle: flush_o=1 and flush_target_o=head.target.
  - CDB writes in the squash cycle are discarded by the invalidation.
- Count update: +1 on dispatch fire only, −1 on commit fire only, unchanged when both or neither fire. A squash overrides all of these and sets count to 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - head=tail=0, count_o=0, all valid/done=0, flush_o=0, flush_target_o=0.
  - Resulting outputs: empty_o=1, full_o=0, disp_ready_o=1, commit_valid_o=0.
  - Reset mid-operation discards all entries with no commit and no flush.
- Entry state visible: a dispatched entry is visible at the next edge.
- Commit latency: a CDB write at edge N makes the entry eligible (commit_valid_o=1) after edge N. The minimum is dispatch→CDB→commit in 3 cycles.
- flush_o is registered; it is high exactly one cycle after the squash edge, then low.
- Wrap-around: pointers wrap modulo DEPTH; full vs empty is resolved by count_o.
- Simultaneous dispatch and commit when count=DEPTH: dispatch is refused and commit proceeds, giving count=DEPTH-1.

## Test plan
- Reset, then dispatch 3 entries (rd=1,2,3) → disp_rob_idx_o 0,1,2; count_o=3; commit_valid_o=0.
- CDB port1 completes idx2 (data 0xC), then port0 completes idx0 (0xA), with commit_ready_i=1 → idx0 retires with rd=1, data=0xA. Head then stalls at idx1 until idx1 completes, after which idx1 and idx2 retire in order.
- Fill DEPTH=32 entries → full_o=1, disp_ready_o=0. Commit one entry while disp_valid_i=1 → no dispatch accepted, count_o=31. Continue dispatch/commit across index 31→0 wrap → tail_idx_o wraps correctly.
- Dispatch a branch at idx4 plus 3 younger entries; complete idx4 with mispredict=1 and target 0x400 → at idx4's commit, all entries invalidate. Next cycle flush_o=1, flush_target_o=0x400, count_o=0, head=tail=5.
- Both CDB ports write idx7 in one cycle with data 0x11 (port0) and 0x22 (port1) → idx7 rd_data=0x22. A CDB write to an unallocated index → no state change.
- Deassert rst_n asynchronously with 5 entries in flight → outputs reach reset values immediately; flush_o stays 0.
